rgb_led_pwm: RTL and testbench
==============================

RGB_LED_PWM -- requirements
Module: rgb_led_pwm

Interface
REQ-001 SHALL have parameter PRESCALE, default 94, CLOCK_24 cycles per PWM phase step (legal 1..65535).
REQ-002 SHALL have parameter LED_ACTIVE_LOW, default 1; 1 means an output pin driven 0 lights the LED.
REQ-003 SHALL have port CLOCK_24  input  1  sole clock.
REQ-004 SHALL have port resetN  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port gpio_led  input  3  per-channel enable from the GPIO controller (bit0 R, bit1 G, bit2 B).
REQ-006 SHALL have port cfg_valid  input  1  configuration request.
REQ-007 SHALL have port cfg_ready  output  1  configuration accept.
REQ-008 SHALL have port cfg_channel  input  2  target channel 0..2; value 3 is reserved.
REQ-009 SHALL have port cfg_duty  input  8  target brightness, 0..255.
REQ-010 SHALL have port cfg_breathe  input  1  0 = static mode, 1 = breathe mode.
REQ-011 SHALL have port led  output  3  registered pin drive to the board RGB LED.

Function
REQ-012 SHALL run a prescaler counting 0..PRESCALE-1 and pulse tick for one cycle when the count wraps to 0.
REQ-013 SHALL keep an 8-bit phase counter that increments on tick and wraps 255->0; that wrap is the period end, pe.
REQ-014 SHALL hold, per channel, target (8b), mode (1b), active duty (8b) and breathe direction (1b).
REQ-015 SHALL accept configuration on a cycle where cfg_valid and cfg_ready are both 1, writing target and mode of cfg_channel.
REQ-016 SHALL drive cfg_ready 1 on every cycle except the cycle that coincides with pe.
REQ-017 SHALL accept and discard configuration writes with cfg_channel=3.
REQ-018 SHALL update active duty only at pe, so the duty never changes mid-period (glitch-free).
REQ-019 Static mode at pe: active duty SHALL load target.
REQ-020 Breathe mode at pe, direction up: active duty SHALL increment by 1; on reaching target, direction SHALL become down.
REQ-021 Breathe mode at pe, direction down: active duty SHALL decrement by 1; on reaching 0, direction SHALL become up.
REQ-022 Breathe mode with active duty above target SHALL force direction down; target 0 SHALL hold active duty at 0.
REQ-023 Arithmetic SHALL saturate at 0 and 255 and never wrap.
REQ-024 A mode change SHALL keep the current active duty; breathe SHALL resume from it with direction up.
REQ-025 Channel i SHALL be lit when gpio_led[i]=1 and phase < active duty[i]; duty 0 is always off, duty 255 is on 255/256 of the period.
REQ-026 led[i] SHALL be registered, one cycle after the phase value it reflects, and inverted when LED_ACTIVE_LOW=1.
REQ-027 gpio_led SHALL be sampled every cycle; a deassert SHALL extinguish the channel one cycle later regardless of phase.

Reset
REQ-028 While resetN=0: prescaler, phase, all durations and targets SHALL be 0, mode static, direction up, cfg_ready 0, and led all-off (3'b111 when LED_ACTIVE_LOW=1, else 3'b000).
REQ-029 Reset asserted mid-period or mid-breathe SHALL abort immediately with no partial state retained.
REQ-030 cfg_ready SHALL rise on the first clock edge after resetN deasserts.

Structure
REQ-031 A shared package SHALL hold the channel index constants (R=0, G=1, B=2, reserved=3), the duty width constant 8 and the mode encoding.
REQ-032 One sub-module, rgb_led_pwm_channel, SHALL be instantiated three times and contain the duty/direction state and compare.
REQ-033 The prescaler, phase counter and cfg decode SHALL be shared in the top of the block.

Verification (PRESCALE=2, LED_ACTIVE_LOW=1)
REQ-034 Reset: resetN=0 at any phase -> led=3'b111, cfg_ready=0; after release, cfg_ready=1 within 1 cycle.
REQ-035 Static duty: write ch0 duty=64 static, gpio_led=3'b001 -> from the next pe, led[0]=0 for exactly 128 cycles of each 512-cycle period.
REQ-036 Boundaries: duty 0 -> led[0] constantly 1; duty 255 -> led[0]=1 for exactly 2 cycles per period.
REQ-037 Write collision: present cfg_valid on the pe cycle -> cfg_ready=0 that cycle, write accepted the next cycle, new duty visible at the following pe.
REQ-038 Breathe: ch2 target=3 breathe -> active duty over successive pe is 1,2,3,2,1,0,1...
REQ-039 Gating: cfg_channel=3 write causes no change to any channel; gpio_led[1] 1->0 mid-period gives led[1]=1 one cycle later.

Source files
------------

// File: rtl/rgb_led_pwm_pkg.sv
// rtl/rgb_led_pwm_pkg.sv - shared constants and encodings for the RGB LED PWM block
//
// Purpose: channel indices, duty width and the mode / breathe-direction
// encodings used by rgb_led_pwm and rgb_led_pwm_channel.
// Ports: none (package).

package rgb_led_pwm_pkg;

   // Channel indices as carried on cfg_channel and used as bit positions
   // in gpio_led / led.
   localparam logic [1:0] CH_R    = 2'd0;
   localparam logic [1:0] CH_G    = 2'd1;
   localparam logic [1:0] CH_B    = 2'd2;
   localparam logic [1:0] CH_RSVD = 2'd3;

   localparam int unsigned        DUTY_W   = 8;
   localparam logic [DUTY_W-1:0]  DUTY_MIN = '0;
   localparam logic [DUTY_W-1:0]  DUTY_MAX = '1;

   typedef enum logic {
      MODE_STATIC  = 1'b0,
      MODE_BREATHE = 1'b1
   } mode_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

endpackage

// File: rtl/rgb_led_pwm_channel.sv
// rtl/rgb_led_pwm_channel.sv - one colour channel: target/mode/duty/direction state and PWM compare
//
// Purpose: holds the configured target and mode of one LED colour, advances
// the active duty once per PWM period (static load or breathe ramp) and
// produces the registered pin drive for that colour.
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   pe         period end strobe (phase wraps 255->0 on this cycle's edge)
//   wr_en      configuration write for this channel
//   wr_target  new target brightness
//   wr_mode    new mode (static / breathe)
//   phase      shared PWM phase counter
//   enable     per-channel enable from the GPIO controller
//   led        registered pin drive (polarity set by LED_ACTIVE_LOW)

module rgb_led_pwm_channel
   import rgb_led_pwm_pkg::*;
#(
   parameter bit LED_ACTIVE_LOW = 1'b1
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pe,
   input  logic              wr_en,
   input  logic [DUTY_W-1:0] wr_target,
   input  mode_e             wr_mode,
   input  logic [DUTY_W-1:0] phase,
   input  logic              enable,
   output logic              led
);

   logic [DUTY_W-1:0] target_q, target_d;
   logic [DUTY_W-1:0] duty_q,   duty_d;
   mode_e             mode_q,   mode_d;
   dir_e              dir_q,    dir_d;
   logic              led_q;
   logic              lit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         target_q <= DUTY_MIN;
         duty_q   <= DUTY_MIN;
         mode_q   <= MODE_STATIC;
         dir_q    <= DIR_UP;
      end else begin
         target_q <= target_d;
         duty_q   <= duty_d;
         mode_q   <= mode_d;
         dir_q    <= dir_d;
      end
   end

   // The top never asserts a write on the pe cycle (cfg_ready is low then),
   // so a write and a duty update are mutually exclusive in one cycle.
   always_comb begin
      target_d = target_q;
      duty_d   = duty_q;
      mode_d   = mode_q;
      dir_d    = dir_q;

      if (wr_en) begin
         target_d = wr_target;
         // Switching mode keeps the current duty; a ramp restarts upward
         // from wherever the duty happens to be.
         if (wr_mode != mode_q) begin
            mode_d = wr_mode;
            dir_d  = DIR_UP;
         end
      end else if (pe) begin
         if (mode_q == MODE_STATIC) begin
            duty_d = target_q;
         end else if (target_q == DUTY_MIN) begin
            duty_d = DUTY_MIN;
            dir_d  = DIR_UP;
         end else if ((dir_q == DIR_DOWN) || (duty_q >= target_q)) begin
            // At or above target the ramp must head down even if it was
            // rising (target lowered, or mode switched at a high duty).
            duty_d = (duty_q == DUTY_MIN) ? DUTY_MIN : duty_q - 1'b1;
            dir_d  = (duty_d == DUTY_MIN) ? DIR_UP : DIR_DOWN;
         end else begin
            duty_d = (duty_q == DUTY_MAX) ? DUTY_MAX : duty_q + 1'b1;
            dir_d  = (duty_d >= target_q) ? DIR_DOWN : DIR_UP;
         end
      end
   end

   // phase < duty gives duty 0 fully dark and duty 255 dark only at phase 255.
   assign lit = enable && (phase < duty_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_q <= LED_ACTIVE_LOW;
      end else begin
         led_q <= lit ^ LED_ACTIVE_LOW;
      end
   end

   assign led = led_q;

endmodule

// File: rtl/rgb_led_pwm.sv
// rtl/rgb_led_pwm.sv - three-channel RGB LED PWM driver with static and breathe modes
//
// Purpose: shared prescaler and 8-bit phase counter, configuration decode
// and three rgb_led_pwm_channel instances driving the board RGB LED.
// Ports:
//   CLOCK_24     sole clock
//   resetN       asynchronous active-low reset
//   gpio_led     per-channel enable (bit0 R, bit1 G, bit2 B)
//   cfg_valid    configuration request
//   cfg_ready    configuration accept (low during reset and on period end)
//   cfg_channel  target channel 0..2, 3 is accepted and dropped
//   cfg_duty     target brightness 0..255
//   cfg_breathe  0 static, 1 breathe
//   led          registered pin drive to the RGB LED

module rgb_led_pwm
   import rgb_led_pwm_pkg::*;
#(
   parameter int unsigned PRESCALE       = 94,
   parameter bit          LED_ACTIVE_LOW = 1'b1
)
(
   input  logic              CLOCK_24,
   input  logic              resetN,
   input  logic [2:0]        gpio_led,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [1:0]        cfg_channel,
   input  logic [DUTY_W-1:0] cfg_duty,
   input  logic              cfg_breathe,
   output logic [2:0]        led
);

   localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

   logic [15:0]       presc_q;
   logic [DUTY_W-1:0] phase_q;
   logic              rdy_q;
   logic              tick;
   logic              pe;
   logic              cfg_hit;
   mode_e             cfg_mode;

   assign tick = (presc_q == PRESC_MAX);
   assign pe   = tick && (phase_q == DUTY_MAX);

   always_ff @(posedge CLOCK_24 or negedge resetN) begin
      if (!resetN) begin
         presc_q <= '0;
         phase_q <= '0;
      end else begin
         presc_q <= tick ? 16'd0 : presc_q + 16'd1;
         if (tick) begin
            phase_q <= phase_q + 1'b1;
         end
      end
   end

   // rdy_q goes high on the first edge out of reset; the pe cycle is then
   // masked so a write can never race the period-end duty update.
   always_ff @(posedge CLOCK_24 or negedge resetN) begin
      if (!resetN) begin
         rdy_q <= 1'b0;
      end else begin
         rdy_q <= 1'b1;
      end
   end

   assign cfg_ready = rdy_q && !pe;
   assign cfg_hit   = cfg_valid && cfg_ready && (cfg_channel != CH_RSVD);
   assign cfg_mode  = mode_e'(cfg_breathe);

   rgb_led_pwm_channel #(.LED_ACTIVE_LOW(LED_ACTIVE_LOW)) u_ch_r (
      .clk       (CLOCK_24),
      .rst_n     (resetN),
      .pe        (pe),
      .wr_en     (cfg_hit && (cfg_channel == CH_R)),
      .wr_target (cfg_duty),
      .wr_mode   (cfg_mode),
      .phase     (phase_q),
      .enable    (gpio_led[CH_R]),
      .led       (led[CH_R])
   );

   rgb_led_pwm_channel #(.LED_ACTIVE_LOW(LED_ACTIVE_LOW)) u_ch_g (
      .clk       (CLOCK_24),
      .rst_n     (resetN),
      .pe        (pe),
      .wr_en     (cfg_hit && (cfg_channel == CH_G)),
      .wr_target (cfg_duty),
      .wr_mode   (cfg_mode),
      .phase     (phase_q),
      .enable    (gpio_led[CH_G]),
      .led       (led[CH_G])
   );

   rgb_led_pwm_channel #(.LED_ACTIVE_LOW(LED_ACTIVE_LOW)) u_ch_b (
      .clk       (CLOCK_24),
      .rst_n     (resetN),
      .pe        (pe),
      .wr_en     (cfg_hit && (cfg_channel == CH_B)),
      .wr_target (cfg_duty),
      .wr_mode   (cfg_mode),
      .phase     (phase_q),
      .enable    (gpio_led[CH_B]),
      .led       (led[CH_B])
   );

endmodule

// File: tb/tb_rgb_led_pwm.sv
// tb/tb_rgb_led_pwm.sv - self-checking bench for rgb_led_pwm (PRESCALE=2, active-low pins)

module tb_rgb_led_pwm;

   localparam int PRESCALE = 2;
   localparam int PERIOD   = 256 * PRESCALE;

   logic       clk = 1'b0;
   logic       resetN;
   logic [2:0] gpio_led;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [1:0] cfg_channel;
   logic [7:0] cfg_duty;
   logic       cfg_breathe;
   logic [2:0] led;

   always #5 clk = ~clk;

   rgb_led_pwm #(.PRESCALE(PRESCALE), .LED_ACTIVE_LOW(1'b1)) dut (
      .CLOCK_24    (clk),
      .resetN      (resetN),
      .gpio_led    (gpio_led),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_channel (cfg_channel),
      .cfg_duty    (cfg_duty),
      .cfg_breathe (cfg_breathe),
      .led         (led)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: k counts clock edges since reset release; everything
   // else (phase, period end, readiness) is arithmetic on k.
   int         k;
   int         m_target[3];
   int         m_duty[3];
   bit         m_breathe[3];
   bit         m_up[3];
   bit         last_acc;
   logic [2:0] exp_led;

   int         lit_cnt[3];
   int         bad_cnt;
   int         bad_k;
   logic [2:0] bad_led;
   logic [2:0] bad_exp;

   function automatic int phase_of(int kk);
      return (kk / PRESCALE) % 256;
   endfunction

   function automatic bit ready_of(int kk);
      return (kk >= 1) && (kk % PERIOD != PERIOD - 1);
   endfunction

   function automatic void model_reset();
      k        = 0;
      last_acc = 1'b0;
      exp_led  = 3'b111;
      for (int i = 0; i < 3; i++) begin
         m_target[i]  = 0;
         m_duty[i]    = 0;
         m_breathe[i] = 1'b0;
         m_up[i]      = 1'b1;
      end
   endfunction

   // Brightness rule applied once per period end.
   function automatic void period_end(int c);
      int nd;
      if (!m_breathe[c]) begin
         m_duty[c] = m_target[c];
      end else if (m_target[c] == 0) begin
         m_duty[c] = 0;
         m_up[c]   = 1'b1;
      end else begin
         if (m_duty[c] >= m_target[c]) m_up[c] = 1'b0;
         nd = m_up[c] ? m_duty[c] + 1 : m_duty[c] - 1;
         if (nd < 0)   nd = 0;
         if (nd > 255) nd = 255;
         m_duty[c] = nd;
         if (nd == 0)                m_up[c] = 1'b1;
         else if (nd >= m_target[c]) m_up[c] = 1'b0;
      end
   endfunction

   // One clock: sample inputs before the edge, advance the model, return
   // 1 time unit after the edge with exp_led describing the new led value.
   task automatic tick_cycle();
      logic [2:0] g;
      logic [1:0] ch;
      logic [7:0] d;
      logic       b;
      int         kb;
      bit         acc;
      g   = gpio_led;
      ch  = cfg_channel;
      d   = cfg_duty;
      b   = cfg_breathe;
      kb  = k;
      acc = cfg_valid && ready_of(kb);
      @(posedge clk);
      for (int i = 0; i < 3; i++)
         exp_led[i] = !(g[i] && (phase_of(kb) < m_duty[i]));
      if (acc && ch != 2'd3) begin
         m_target[int'(ch)] = int'(d);
         if (b != m_breathe[int'(ch)]) begin
            m_breathe[int'(ch)] = b;
            m_up[int'(ch)]      = 1'b1;
         end
      end
      if (kb % PERIOD == PERIOD - 1)
         for (int i = 0; i < 3; i++) period_end(i);
      k++;
      last_acc = acc;
      #1;
   endtask

   task automatic cfg_write(input logic [1:0] ch, input logic [7:0] d, input logic b);
      cfg_valid   = 1'b1;
      cfg_channel = ch;
      cfg_duty    = d;
      cfg_breathe = b;
      do tick_cycle(); while (!last_acc);
      cfg_valid = 1'b0;
   endtask

   task automatic align_pe();
      while (k % PERIOD != 0) tick_cycle();
   endtask

   // One full period of samples: per-channel lit counts plus mismatches
   // against the model.
   task automatic measure_period();
      for (int i = 0; i < 3; i++) lit_cnt[i] = 0;
      bad_cnt = 0;
      bad_k   = -1;
      for (int c = 0; c < PERIOD; c++) begin
         tick_cycle();
         for (int i = 0; i < 3; i++) if (led[i] === 1'b0) lit_cnt[i]++;
         if (led !== exp_led || cfg_ready !== ready_of(k)) begin
            if (bad_cnt == 0) begin
               bad_k   = k;
               bad_led = led;
               bad_exp = exp_led;
            end
            bad_cnt++;
         end
      end
   endtask

   task automatic test_reset();
      int n;
      checks++;
      if (led !== 3'b111 || cfg_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_initial led=%b rdy=%b expected led=111 rdy=0", led, cfg_ready);
      end
      tick_cycle();
      checks++;
      if (cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready_rise rdy=%b expected 1", cfg_ready);
      end
      gpio_led = 3'b111;
      cfg_write(2'd0, 8'd200, 1'b0);
      cfg_write(2'd1, 8'd50, 1'b1);
      cfg_write(2'd2, 8'd255, 1'b0);
      n = $urandom_range(600, 1400);
      repeat (n) tick_cycle();
      #2 resetN = 1'b0;
      #1;
      checks++;
      if (led !== 3'b111 || cfg_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_async led=%b rdy=%b expected led=111 rdy=0", led, cfg_ready);
      end
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (led !== 3'b111 || cfg_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold led=%b rdy=%b expected led=111 rdy=0", led, cfg_ready);
      end
      resetN = 1'b1;
      tick_cycle();
      checks++;
      if (cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready_1cycle rdy=%b expected 1", cfg_ready);
      end
      measure_period();
      checks++;
      if (bad_cnt != 0 || lit_cnt[0] + lit_cnt[1] + lit_cnt[2] != 0) begin
         errors++;
         $display("FAIL reset_no_residue lit=%0d/%0d/%0d bad=%0d expected all 0", lit_cnt[0], lit_cnt[1], lit_cnt[2], bad_cnt);
      end
   endtask

   task automatic test_static();
      gpio_led = 3'b001;
      cfg_write(2'd0, 8'd64, 1'b0);
      align_pe();
      measure_period();
      checks++;
      if (lit_cnt[0] != 128) begin
         errors++;
         $display("FAIL static_64_lit lit=%0d expected 128", lit_cnt[0]);
      end
      checks++;
      if (bad_cnt != 0) begin
         errors++;
         $display("FAIL static_trace k=%0d led=%b expected %b (%0d mismatches)", bad_k, bad_led, bad_exp, bad_cnt);
      end
   endtask

   task automatic test_boundaries();
      cfg_write(2'd0, 8'd0, 1'b0);
      align_pe();
      measure_period();
      checks++;
      if (lit_cnt[0] != 0 || bad_cnt != 0) begin
         errors++;
         $display("FAIL duty0_dark lit=%0d expected 0 (bad=%0d)", lit_cnt[0], bad_cnt);
      end
      cfg_write(2'd0, 8'd255, 1'b0);
      align_pe();
      measure_period();
      checks++;
      if (PERIOD - lit_cnt[0] != 2 || bad_cnt != 0) begin
         errors++;
         $display("FAIL duty255_dark dark=%0d expected 2 (bad=%0d)", PERIOD - lit_cnt[0], bad_cnt);
      end
   endtask

   task automatic test_collision();
      while (k % PERIOD != PERIOD - 1) tick_cycle();
      cfg_valid   = 1'b1;
      cfg_channel = 2'd0;
      cfg_duty    = 8'd100;
      cfg_breathe = 1'b0;
      #1;
      checks++;
      if (cfg_ready !== 1'b0) begin
         errors++;
         $display("FAIL collision_ready_low rdy=%b expected 0", cfg_ready);
      end
      tick_cycle();
      checks++;
      if (cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL collision_ready_next rdy=%b expected 1", cfg_ready);
      end
      tick_cycle();
      cfg_valid = 1'b0;
      while (k % PERIOD != 0) begin
         tick_cycle();
         checks++;
         if (led !== exp_led) begin
            errors++;
            $display("FAIL collision_old_duty k=%0d led=%b expected %b", k, led, exp_led);
         end
      end
      measure_period();
      checks++;
      if (lit_cnt[0] != 200 || bad_cnt != 0) begin
         errors++;
         $display("FAIL collision_new_duty lit=%0d expected 200 (bad=%0d)", lit_cnt[0], bad_cnt);
      end
   endtask

   task automatic test_breathe();
      int exp_seq[7] = '{2, 4, 6, 4, 2, 0, 2};
      gpio_led = 3'b100;
      cfg_write(2'd2, 8'd3, 1'b1);
      align_pe();
      for (int p = 0; p < 7; p++) begin
         measure_period();
         checks++;
         if (lit_cnt[2] != exp_seq[p] || bad_cnt != 0) begin
            errors++;
            $display("FAIL breathe_step%0d lit=%0d expected %0d (bad=%0d)", p, lit_cnt[2], exp_seq[p], bad_cnt);
         end
      end
   endtask

   task automatic test_gating();
      gpio_led = 3'b111;
      cfg_write(2'd1, 8'd128, 1'b0);
      cfg_write(2'd3, 8'd200, 1'b1);
      align_pe();
      measure_period();
      checks++;
      if (lit_cnt[0] != 200 || lit_cnt[1] != 256 || bad_cnt != 0) begin
         errors++;
         $display("FAIL reserved_discard lit0=%0d lit1=%0d expected 200/256 (bad=%0d)", lit_cnt[0], lit_cnt[1], bad_cnt);
      end
      repeat (20) tick_cycle();
      checks++;
      if (led[1] !== 1'b0) begin
         errors++;
         $display("FAIL gate_lit_before led1=%b expected 0", led[1]);
      end
      gpio_led[1] = 1'b0;
      tick_cycle();
      checks++;
      if (led[1] !== 1'b1) begin
         errors++;
         $display("FAIL gate_off led1=%b expected 1", led[1]);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 16 * PERIOD; c++) begin
         if (!cfg_valid && $urandom_range(0, 31) == 0) begin
            cfg_valid   = 1'b1;
            cfg_channel = 2'($urandom_range(0, 3));
            cfg_duty    = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 6)) : 8'($urandom_range(0, 255));
            cfg_breathe = 1'($urandom_range(0, 1));
         end
         if ($urandom_range(0, 99) == 0) gpio_led = 3'($urandom_range(0, 7));
         tick_cycle();
         if (last_acc) cfg_valid = 1'b0;
         checks++;
         if (led !== exp_led || cfg_ready !== ready_of(k)) begin
            errors++;
            if (errors < 20)
               $display("FAIL random k=%0d led=%b rdy=%b expected led=%b rdy=%b", k, led, cfg_ready, exp_led, ready_of(k));
         end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      resetN      = 1'b0;
      gpio_led    = 3'b000;
      cfg_valid   = 1'b0;
      cfg_channel = 2'd0;
      cfg_duty    = 8'd0;
      cfg_breathe = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 resetN = 1'b1;
      test_reset();
      test_static();
      test_boundaries();
      test_collision();
      test_breathe();
      test_gating();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
